// File: rtl/gestor_conmutacion_baterias_if.sv
// Bundle of signals between the discharge detector, the battery switch
// manager and the power-path switch / front-panel LED.
// The master side drives the raw discharged flags and watches the results.
// The slave side is the manager itself.
interface gestor_conmutacion_baterias_if;
    logic advertencia_bateria_1;
    logic advertencia_bateria_2;
    logic seleccion_bateria;
    logic carga_habilitada;
    logic cambio_pulso;
    logic alarma_led;
    logic ambas_descargadas;

    modport master (
        output advertencia_bateria_1,
        output advertencia_bateria_2,
        input  seleccion_bateria,
        input  carga_habilitada,
        input  cambio_pulso,
        input  alarma_led,
        input  ambas_descargadas
    );

    modport slave (
        input  advertencia_bateria_1,
        input  advertencia_bateria_2,
        output seleccion_bateria,
        output carga_habilitada,
        output cambio_pulso,
        output alarma_led,
        output ambas_descargadas
    );
endinterface

// File: rtl/gestor_conmutacion_baterias.sv
// Battery switch manager.
// Each raw discharged flag is debounced by a symmetric sample-count filter.
// A three-state selector then decides which battery feeds the load.
// The outputs are registered from the next state, so they move on the same
// edge as the state. While both batteries are empty the LED blinks with a
// half-period of PERIODO_PARPADEO cycles.
module gestor_conmutacion_baterias #(
    parameter int FILTRO_CICLOS    = 4,
    parameter int PERIODO_PARPADEO = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    gestor_conmutacion_baterias_if.slave  bus
);

    localparam int CW = $clog2(FILTRO_CICLOS + 1);
    localparam int BW = $clog2(PERIODO_PARPADEO + 1);
    localparam logic [CW-1:0] CNT_ULT = CW'(FILTRO_CICLOS - 1);
    localparam logic [BW-1:0] BLK_ULT = BW'(PERIODO_PARPADEO - 1);

    typedef enum logic [1:0] {
        USA_B1      = 2'd0,
        USA_B2      = 2'd1,
        SIN_ENERGIA = 2'd2
    } estado_t;

    // Raw flags packed as {battery 2, battery 1}
    logic [1:0]    raw;
    logic [1:0]    f_q, f_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    estado_t       estado_q, estado_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          sel_q, sel_d;
    logic          carga_q, carga_d;
    logic          pulso_q, pulso_d;
    logic          led_q, led_d;
    logic          ambas_q, ambas_d;

    assign raw = {bus.advertencia_bateria_2, bus.advertencia_bateria_1};

    // Debounce: a flag flips only after FILTRO_CICLOS consecutive disagreeing samples
    always_comb begin
        f_d = f_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (raw[i] != f_q[i]) begin
                if (cnt_q[i] == CNT_ULT) begin
                    f_d[i] = ~f_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q      <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            f_q      <= f_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // Selector next state plus output decode.
    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        estado_d = estado_q;
        blk_d    = '0;
        led_d    = 1'b0;
        pulso_d  = 1'b0;

        case (estado_q)
            USA_B1: begin
                if (f_q[0] && f_q[1]) begin
                    estado_d = SIN_ENERGIA;
                end else if (f_q[0]) begin
                    estado_d = USA_B2;
                end
            end
            USA_B2: begin
                if (f_q[0] && f_q[1]) begin
                    estado_d = SIN_ENERGIA;
                end else if (f_q[1]) begin
                    estado_d = USA_B1;
                end
            end
            SIN_ENERGIA: begin
                // Battery 1 wins when both recover on the same edge
                if (!f_q[0]) begin
                    estado_d = USA_B1;
                end else if (!f_q[1]) begin
                    estado_d = USA_B2;
                end
            end
            default: estado_d = USA_B1;
        endcase

        sel_d   = (estado_d == USA_B2);
        carga_d = (estado_d != SIN_ENERGIA);
        ambas_d = (estado_d == SIN_ENERGIA);

        // Pulse only on a direct battery swap.
        // The pulse is suppressed right after a previous one, so it never lasts two cycles.
        if (((estado_q == USA_B1) && (estado_d == USA_B2)) ||
            ((estado_q == USA_B2) && (estado_d == USA_B1))) begin
            pulso_d = !pulso_q;
        end

        if (estado_d == SIN_ENERGIA) begin
            if (estado_q != SIN_ENERGIA) begin
                // Entry: start with the LED lit and a fresh half-period
                led_d = 1'b1;
                blk_d = '0;
            end else if (blk_q == BLK_ULT) begin
                led_d = ~led_q;
                blk_d = '0;
            end else begin
                led_d = led_q;
                blk_d = blk_q + BW'(1);
            end
        end else begin
            // Steady on when one battery is flagged, off when none is
            led_d = f_q[0] | f_q[1];
        end
    end

    // Selector state, blink counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= USA_B1;
            blk_q    <= '0;
            sel_q    <= 1'b0;
            carga_q  <= 1'b1;
            pulso_q  <= 1'b0;
            led_q    <= 1'b0;
            ambas_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            blk_q    <= blk_d;
            sel_q    <= sel_d;
            carga_q  <= carga_d;
            pulso_q  <= pulso_d;
            led_q    <= led_d;
            ambas_q  <= ambas_d;
        end
    end

    assign bus.seleccion_bateria = sel_q;
    assign bus.carga_habilitada  = carga_q;
    assign bus.cambio_pulso      = pulso_q;
    assign bus.alarma_led        = led_q;
    assign bus.ambas_descargadas = ambas_q;

endmodule

// File: tb/tb_gestor_conmutacion_baterias.sv
// Bench for the battery switch manager (FILTRO_CICLOS=4, PERIODO_PARPADEO=8).
// Expected output vectors {sel, carga, pulso, led, ambas} are queued per cycle
// and popped after each rising edge.
module tb_gestor_conmutacion_baterias;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gestor_conmutacion_baterias_if bus();

    gestor_conmutacion_baterias #(
        .FILTRO_CICLOS    (4),
        .PERIODO_PARPADEO (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {seleccion, carga, pulso, led, ambas}
    localparam logic [4:0] E_B1     = 5'b01000;
    localparam logic [4:0] E_B2     = 5'b11010;
    localparam logic [4:0] E_B2P    = 5'b11110;
    localparam logic [4:0] E_SIN_ON = 5'b00011;
    localparam logic [4:0] E_SIN_OF = 5'b00001;

    logic [4:0] obs;
    assign obs = {bus.seleccion_bateria, bus.carga_habilitada, bus.cambio_pulso,
                  bus.alarma_led, bus.ambas_descargadas};

    logic [4:0] sb_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic test_reset();
        logic [4:0] e;
        rst = 1'b1;
        bus.advertencia_bateria_1 = 1'b0;
        bus.advertencia_bateria_2 = 1'b0;
        #2;
        sb_q.push_back(E_B1);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", obs, e);
        end
        sb_q.push_back(E_B1);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected %b", obs, e);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        logic [4:0] e;
        for (int k = 0; k < 20; k++) begin
            bus.advertencia_bateria_1 = 1'b0;
            bus.advertencia_bateria_2 = 1'b0;
            sb_q.push_back(E_B1);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL idle cyc%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [4:0] e;
        for (int k = 0; k < 8; k++) begin
            bus.advertencia_bateria_1 = (k < 3);
            bus.advertencia_bateria_2 = 1'b0;
            sb_q.push_back(E_B1);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL glitch cyc%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_switch_b2();
        logic [4:0] e;
        for (int k = 0; k < 8; k++) begin
            bus.advertencia_bateria_1 = 1'b1;
            bus.advertencia_bateria_2 = 1'b0;
            sb_q.push_back((k < 4) ? E_B1 : ((k == 4) ? E_B2P : E_B2));
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL switch_b2 cyc%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_both_discharged();
        logic [4:0] e;
        for (int k = 0; k < 28; k++) begin
            bus.advertencia_bateria_1 = 1'b1;
            bus.advertencia_bateria_2 = 1'b1;
            if (k < 4)
                sb_q.push_back(E_B2);
            else
                sb_q.push_back(((((k - 4) / 8) % 2) == 0) ? E_SIN_ON : E_SIN_OF);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL blink cyc%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_recover();
        logic [4:0] e;
        for (int k = 0; k < 8; k++) begin
            bus.advertencia_bateria_1 = 1'b0;
            bus.advertencia_bateria_2 = 1'b0;
            sb_q.push_back((k < 4) ? E_SIN_OF : E_B1);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL recover cyc%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_priority();
        logic [4:0] e;
        for (int k = 0; k < 14; k++) begin
            bus.advertencia_bateria_1 = 1'b1;
            bus.advertencia_bateria_2 = (k < 8);
            if (k < 4)       sb_q.push_back(E_B1);
            else if (k < 12) sb_q.push_back(E_SIN_ON);
            else             sb_q.push_back(E_B2);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL priority cyc%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        // Back into the empty state, then leave filter 1 part-way through a count
        for (int k = 0; k < 11; k++) begin
            bus.advertencia_bateria_1 = (k < 9);
            bus.advertencia_bateria_2 = 1'b1;
            sb_q.push_back((k < 4) ? E_B2 : E_SIN_ON);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL pre_reset cyc%0d: got %b expected %b", k, obs, e);
            end
        end
        rst = 1'b1;
        #2;
        sb_q.push_back(E_B1);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b expected %b", obs, e);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.advertencia_bateria_1 = 1'b0;
        bus.advertencia_bateria_2 = 1'b0;
        sb_q.push_back(E_B1);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_release: got %b expected %b", obs, e);
        end
        for (int k = 0; k < 7; k++) begin
            bus.advertencia_bateria_1 = (k < 3);
            bus.advertencia_bateria_2 = (k < 3);
            sb_q.push_back(E_B1);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL post_reset_pulse cyc%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_glitch();
        test_switch_b2();
        test_both_discharged();
        test_recover();
        test_priority();
        test_reset_mid();
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
